// File: rtl/alu_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter_if: requester, shared-ALU and response bundle for alu_arbiter |
// | Optional grant_cnt present with ALU_ARB_CNT_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if;
  logic [3:0]  req;
  logic [7:0]  op_in;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  gnt;
  logic [1:0]  alu_opcode;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [4:0]  alu_c;
  logic [3:0]  rsp_valid;
  logic [4:0]  rsp_data;
  logic        busy;
`ifdef ALU_ARB_CNT_EN
  logic [31:0] grant_cnt;
`endif

  modport slave (
    input  req, op_in, a_in, b_in, alu_c,
    output gnt, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, busy
`ifdef ALU_ARB_CNT_EN
    , output grant_cnt
`endif
  );

  modport master (
    output req, op_in, a_in, b_in, alu_c,
    input  gnt, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, busy
`ifdef ALU_ARB_CNT_EN
    , input grant_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter: 4-way round-robin arbiter sharing one 1-cycle-latency ALU    |
// | ALU_ARB_CNT_EN adds per-requester saturating grant counters.  Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  owner_q;
  logic [3:0]  gnt_q;
  logic [1:0]  alu_opcode_q;
  logic [3:0]  alu_a_q;
  logic [3:0]  alu_b_q;
  logic [3:0]  rsp_valid_q;
  logic [4:0]  rsp_data_q;
  logic        busy_q;

  logic [1:0]  win_d;
  logic        hit_d;
  logic [1:0]  idx_d;
  logic [1:0]  op_d;
  logic [3:0]  a_d;
  logic [3:0]  b_d;

  // Scan from the farthest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    win_d = rr_ptr_q;
    hit_d = 1'b0;
    idx_d = '0;
    for (int k = 3; k >= 0; k--) begin
      idx_d = rr_ptr_q + 2'(k);
      if (bus.req[idx_d]) begin
        win_d = idx_d;
        hit_d = 1'b1;
      end
    end
    op_d = '0;
    a_d  = '0;
    b_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (win_d == 2'(i)) begin
        op_d = bus.op_in[2*i +: 2];
        a_d  = bus.a_in[4*i +: 4];
        b_d  = bus.b_in[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      gnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (hit_d) begin
            state_q      <= EXEC;
            owner_q      <= win_d;
            rr_ptr_q     <= win_d + 2'd1;
            gnt_q        <= 4'b0001 << win_d;
            alu_opcode_q <= op_d;
            alu_a_q      <= a_d;
            alu_b_q      <= b_d;
            busy_q       <= 1'b1;
          end
        end
        EXEC: state_q <= CAPT;
        CAPT: begin
          // alu_c holds the result of the operands launched in EXEC.
          state_q     <= IDLE;
          rsp_data_q  <= bus.alu_c;
          rsp_valid_q <= 4'b0001 << owner_q;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;

`ifdef ALU_ARB_CNT_EN
  logic grant_fire;
  assign grant_fire = (state_q == IDLE) && hit_d;

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (grant_fire && (win_d == 2'(i)) && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
    assign bus.grant_cnt[8*i +: 8] = cnt_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench with a 1-cycle ALU model     |
// | Counter checks compiled in with ALU_ARB_CNT_EN.  Rev 1.0                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared ALU: 0 add, 1 sub, 2 and, 3 or; registered 5-bit signed result.
  always @(posedge clk) begin
    case (bus.alu_opcode)
      2'd0:    bus.alu_c <= {bus.alu_a[3], bus.alu_a} + {bus.alu_b[3], bus.alu_b};
      2'd1:    bus.alu_c <= {bus.alu_a[3], bus.alu_a} - {bus.alu_b[3], bus.alu_b};
      2'd2:    bus.alu_c <= {bus.alu_a[3], bus.alu_a} & {bus.alu_b[3], bus.alu_b};
      default: bus.alu_c <= {bus.alu_a[3], bus.alu_a} | {bus.alu_b[3], bus.alu_b};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] order [5];
  logic [4:0] res_tbl [4];
  logic [3:0] a_tbl [4];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req   = '0;
    bus.op_in = '0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    order   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    res_tbl = '{5'h03, 5'h04, 5'h02, 5'h05};
    a_tbl   = '{4'h1, 4'h5, 4'h6, 4'h4};

    // Reset state
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 4'h0);
    chk("rst_rsp_data", bus.rsp_data, 5'h00);
    chk("rst_alu_op", bus.alu_opcode, 2'h0);
    chk("rst_alu_a", bus.alu_a, 4'h0);
    chk("rst_alu_b", bus.alu_b, 4'h0);
    chk("rst_busy", bus.busy, 1'b0);
`ifdef ALU_ARB_CNT_EN
    chk("rst_grant_cnt", bus.grant_cnt, 32'h0);
`endif
    reset = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 1'b0);

    // All requesting: r0 1+2=3, r1 5-1=4, r2 6&3=2, r3 4|1=5
    bus.op_in = 8'hE4;
    bus.a_in  = 16'h4651;
    bus.b_in  = 16'h1312;
    bus.req   = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("all_gnt", bus.gnt, 4'b0001 << order[n]);
      chk("all_gnt_rspv", bus.rsp_valid, 4'h0);
      chk("all_alu_a", bus.alu_a, a_tbl[order[n]]);
      chk("all_busy_exec", bus.busy, 1'b1);
      if (n == 4) bus.req = 4'b0000;
      tick();
      chk("all_gnt_pulse", bus.gnt, 4'h0);
      chk("all_busy_capt", bus.busy, 1'b1);
      tick();
      chk("all_rsp_valid", bus.rsp_valid, 4'b0001 << order[n]);
      chk("all_rsp_data", bus.rsp_data, res_tbl[order[n]]);
      chk("all_rsp_gnt", bus.gnt, 4'h0);
      chk("all_busy_rsp", bus.busy, 1'b0);
    end
    tick();
    chk("all_idle_gnt", bus.gnt, 4'h0);
    chk("all_idle_rspv", bus.rsp_valid, 4'h0);
    chk("all_idle_busy", bus.busy, 1'b0);

    // Wrap: pointer at 1, req=1001 -> 3 then 0
    bus.req = 4'b1001;
    tick();
    chk("wrap_gnt3", bus.gnt, 4'b1000);
    tick();
    tick();
    chk("wrap_rsp3", bus.rsp_valid, 4'b1000);
    chk("wrap_data3", bus.rsp_data, 5'h05);
    tick();
    chk("wrap_gnt0", bus.gnt, 4'b0001);
    chk("wrap_no_overlap", bus.rsp_valid, 4'h0);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("wrap_rsp0", bus.rsp_valid, 4'b0001);
    chk("wrap_data0", bus.rsp_data, 5'h03);
    tick();
    chk("wrap_idle_rspv", bus.rsp_valid, 4'h0);

    // Single request: 7+7=14
    bus.op_in = 8'hE4;
    bus.a_in  = 16'h0007;
    bus.b_in  = 16'h0007;
    bus.req   = 4'b0001;
    tick();
    chk("single_gnt", bus.gnt, 4'b0001);
    chk("single_op", bus.alu_opcode, 2'd0);
    chk("single_a", bus.alu_a, 4'h7);
    chk("single_b", bus.alu_b, 4'h7);
    bus.req = 4'b0000;
    tick();
    chk("single_rspv_early", bus.rsp_valid, 4'h0);
    tick();
    chk("single_rspv", bus.rsp_valid, 4'b0001);
    chk("single_data", bus.rsp_data, 5'h0E);
    chk("single_a_hold", bus.alu_a, 4'h7);
    tick();
    chk("single_rspv_pulse", bus.rsp_valid, 4'h0);

    // Subtraction on requester 2: -8-7=-15
    bus.op_in = 8'hD4;
    bus.a_in  = 16'h0800;
    bus.b_in  = 16'h0700;
    bus.req   = 4'b0100;
    chk("sub_busy_pre", bus.busy, 1'b0);
    tick();
    chk("sub_gnt", bus.gnt, 4'b0100);
    chk("sub_op", bus.alu_opcode, 2'd1);
    chk("sub_a", bus.alu_a, 4'h8);
    chk("sub_b", bus.alu_b, 4'h7);
    chk("sub_busy1", bus.busy, 1'b1);
    bus.req = 4'b0000;
    tick();
    chk("sub_busy2", bus.busy, 1'b1);
    tick();
    chk("sub_busy3", bus.busy, 1'b0);
    chk("sub_rspv", bus.rsp_valid, 4'b0100);
    chk("sub_data", bus.rsp_data, 5'h11);

    // Reset during CAPT: pointer at 3, req=0010 -> grant 1, then abort
    bus.req = 4'b0010;
    tick();
    chk("abort_gnt", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    tick();
    chk("abort_busy_capt", bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_gnt0", bus.gnt, 4'h0);
    chk("abort_rspv0", bus.rsp_valid, 4'h0);
    chk("abort_data0", bus.rsp_data, 5'h00);
    chk("abort_op0", bus.alu_opcode, 2'h0);
    chk("abort_a0", bus.alu_a, 4'h0);
    chk("abort_b0", bus.alu_b, 4'h0);
    chk("abort_busy0", bus.busy, 1'b0);
    tick();
    chk("abort_no_rsp", bus.rsp_valid, 4'h0);
    reset   = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk("abort_next_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("abort_next_rsp", bus.rsp_valid, 4'b0001);

`ifdef ALU_ARB_CNT_EN
    // 300 back-to-back grants to requester 1 saturate its counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 4'b0010;
    for (int n = 0; n < 300; n++) begin
      tick();
      tick();
      tick();
    end
    bus.req = 4'b0000;
    tick();
    tick();
    tick();
    chk("cnt_saturated", bus.grant_cnt, 32'h0000FF00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL provide the following ports (name  direction  width  meaning):
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 op_in  input  8  requester i opcode at bits [2i+1:2i].
REQ-006 a_in  input  16  requester i signed operand A at bits [4i+3:4i].
REQ-007 b_in  input  16  requester i signed operand B at bits [4i+3:4i].
REQ-008 gnt  output  4  one-hot grant pulse.
REQ-009 alu_opcode  output  2  registered opcode driven to the shared ALU_4_bit.
REQ-010 alu_a  output  4  registered signed A driven to the ALU.
REQ-011 alu_b  output  4  registered signed B driven to the ALU.
REQ-012 alu_c  input  5  signed registered result from the ALU (1-cycle ALU latency).
REQ-013 rsp_valid  output  4  one-hot response strobe to the owning requester.
REQ-014 rsp_data  output  5  signed result, valid only while rsp_valid is non-zero.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, EXEC and CAPT; the transitions are IDLE->EXEC on any req bit, EXEC->CAPT unconditionally, and CAPT->IDLE unconditionally.
REQ-017 At the edge leaving IDLE, the block SHALL select winner w by round-robin search starting at rr_ptr, load alu_opcode/alu_a/alu_b from slice w, and set gnt to one-hot w for exactly one cycle (the EXEC cycle).
REQ-018 rr_ptr SHALL be updated to (w+1) mod 4 on each grant; wrap from 3 to 0 is required.
REQ-019 alu_opcode/alu_a/alu_b SHALL hold their values through EXEC and CAPT and SHALL NOT change outside a grant edge.
REQ-020 At the edge leaving CAPT, the block SHALL register alu_c into rsp_data and raise rsp_valid[w] for exactly one cycle.
REQ-021 Latency SHALL be 3 cycles from the grant-sampling edge to rsp_valid; sustained throughput SHALL be one operation per 3 cycles.
REQ-022 A new grant MAY occur at the edge ending the cycle in which rsp_valid is high; rsp_valid and a new gnt SHALL therefore never overlap.
REQ-023 The requester SHALL hold req and operands stable until gnt; a req bit still high in the next IDLE SHALL be treated as a new request.
REQ-024 req changes during EXEC/CAPT SHALL be ignored; only IDLE samples req.
REQ-025 Opcode and operand bits SHALL pass to the ALU unmodified; no arithmetic is performed in this block.

Reset
REQ-026 While reset is high: state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_data=0, alu_opcode=0, alu_a=0, alu_b=0, busy=0.
REQ-027 Reset asserted in EXEC or CAPT SHALL abort the in-flight operation with no rsp_valid generated.

Configuration
REQ-028 With ALU_ARB_CNT_EN defined, the block SHALL add output grant_cnt (32 bits): per-requester 8-bit saturating grant counters at bits [8i+7:8i], cleared by reset, incremented at each grant, and held at 255.
REQ-029 Without ALU_ARB_CNT_EN, neither the grant_cnt port nor the counters SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-030 Single request: req=0001, op0=0, A0=7, B0=7 -> gnt=0001 one cycle later, rsp_valid=0001 with rsp_data=14 three cycles after the sampling edge.
REQ-031 All requesting: req=1111 held continuously -> grant order 0,1,2,3,0, with responses spaced every 3 cycles.
REQ-032 Wrap/fairness: after a grant to requester 3, req=1001 -> the next grant goes to requester 0.
REQ-033 Subtraction routing: req=0100, op2=1, A2=-8, B2=7 -> rsp_valid=0100 with rsp_data=-15 and busy high for 2 cycles.
REQ-034 Reset during CAPT -> no rsp_valid, all outputs 0, and the next request is served starting from requester 0.
REQ-035 With ALU_ARB_CNT_EN defined, 300 grants to requester 1 -> grant_cnt[15:8]=255.
